// File: rtl/riscv_mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single-port memory, with
// starvation-bounded data priority. Define RISCV_MEM_ARBITER_STATS_EN for stall counters.
module riscv_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_gnt_o,
    output logic        i_rvalid_o,
    output logic [31:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [1:0]  d_size_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [1:0]  m_size_o,
    output logic        m_rd_o,
    output logic        m_wr_o,
    input  logic [31:0] m_rdata_i,
    output logic [31:0] i_stall_cnt_o,
    output logic [31:0] d_stall_cnt_o,
    output logic        dbg_state_o
);

    // Handshake: a requester holds req/addr stable until the cycle its gnt is 1;
    // that cycle is the transfer, and a read's rvalid/rdata follow exactly one cycle later.

    localparam int LIM = (STARVE_LIMIT < 1) ? 1 : STARVE_LIMIT;
    localparam int CW  = ($clog2(LIM + 1) > 3) ? $clog2(LIM + 1) : 3;

    typedef enum logic {
        PRIO_D = 1'b0,
        PRIO_I = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    state_e        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    owner_e        owner_q, owner_d;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        i_gnt_o  = 1'b0;
        d_gnt_o  = 1'b0;

        if (reset_i) begin
            if (i_req_i && d_req_i) begin
                i_gnt_o = (state_q == PRIO_I);
                d_gnt_o = (state_q != PRIO_I);
            end else begin
                i_gnt_o = i_req_i;
                d_gnt_o = d_req_i;
            end
        end

        case (state_q)
            PRIO_D: begin
                if (i_req_i && !i_gnt_o) begin
                    // Hand priority over on the denial that would reach the limit.
                    if ((starve_q + CW'(1)) >= CW'(LIM)) begin
                        state_d  = PRIO_I;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + CW'(1);
                    end
                end else begin
                    starve_d = '0;
                end
            end
            PRIO_I: begin
                starve_d = '0;
                if (i_gnt_o || !i_req_i) begin
                    state_d = PRIO_D;
                end
            end
            default: begin
                state_d  = PRIO_D;
                starve_d = '0;
            end
        endcase
    end

    always_comb begin
        m_addr_o  = '0;
        m_wdata_o = '0;
        m_size_o  = '0;
        m_rd_o    = 1'b0;
        m_wr_o    = 1'b0;
        owner_d   = OWN_NONE;
        if (i_gnt_o) begin
            m_addr_o = i_addr_i;
            m_size_o = 2'd2;
            m_rd_o   = 1'b1;
            owner_d  = OWN_I;
        end else if (d_gnt_o) begin
            m_addr_o  = d_addr_i;
            m_wdata_o = d_wdata_i;
            m_size_o  = d_size_i;
            m_rd_o    = ~d_we_i;
            m_wr_o    = d_we_i;
            owner_d   = d_we_i ? OWN_NONE : OWN_D;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= PRIO_D;
            starve_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    // Read data is passed straight through in the response cycle, steered by owner.
    assign i_rvalid_o  = (owner_q == OWN_I);
    assign d_rvalid_o  = (owner_q == OWN_D);
    assign i_rdata_o   = i_rvalid_o ? m_rdata_i : 32'd0;
    assign d_rdata_o   = d_rvalid_o ? m_rdata_i : 32'd0;
    assign dbg_state_o = state_q;

`ifdef RISCV_MEM_ARBITER_STATS_EN
    logic [31:0] i_stall_q, i_stall_d;
    logic [31:0] d_stall_q, d_stall_d;

    always_comb begin
        i_stall_d = i_stall_q;
        d_stall_d = d_stall_q;
        if (i_req_i && !i_gnt_o && (i_stall_q != 32'hFFFF_FFFF)) begin
            i_stall_d = i_stall_q + 32'd1;
        end
        if (d_req_i && !d_gnt_o && (d_stall_q != 32'hFFFF_FFFF)) begin
            d_stall_d = d_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            i_stall_q <= '0;
            d_stall_q <= '0;
        end else begin
            i_stall_q <= i_stall_d;
            d_stall_q <= d_stall_d;
        end
    end

    assign i_stall_cnt_o = i_stall_q;
    assign d_stall_cnt_o = d_stall_q;
`else
    assign i_stall_cnt_o = 32'd0;
    assign d_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: directed scenarios plus random traffic
// checked against a denial-run arbitration model and per-port response queues.
module tb_riscv_mem_arbiter;

    localparam int STARVE = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_gnt_o;
    logic        i_rvalid_o;
    logic [31:0] i_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [1:0]  d_size_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [1:0]  m_size_o;
    logic        m_rd_o;
    logic        m_wr_o;
    logic [31:0] m_rdata_i;
    logic [31:0] i_stall_cnt_o;
    logic [31:0] d_stall_cnt_o;
    logic        dbg_state_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] i_exp_q[$];
    logic [31:0] d_exp_q[$];
    int          i_due_q[$];
    int          d_due_q[$];

    riscv_mem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .i_req_i       (i_req_i),
        .i_addr_i      (i_addr_i),
        .i_gnt_o       (i_gnt_o),
        .i_rvalid_o    (i_rvalid_o),
        .i_rdata_o     (i_rdata_o),
        .d_req_i       (d_req_i),
        .d_we_i        (d_we_i),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_size_i      (d_size_i),
        .d_gnt_o       (d_gnt_o),
        .d_rvalid_o    (d_rvalid_o),
        .d_rdata_o     (d_rdata_o),
        .m_addr_o      (m_addr_o),
        .m_wdata_o     (m_wdata_o),
        .m_size_o      (m_size_o),
        .m_rd_o        (m_rd_o),
        .m_wr_o        (m_wr_o),
        .m_rdata_i     (m_rdata_i),
        .i_stall_cnt_o (i_stall_cnt_o),
        .d_stall_cnt_o (d_stall_cnt_o),
        .dbg_state_o   (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3} + 32'd7;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        tick();
        reset_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b1;
    endtask

    // Memory: returns the word for the address read in the previous cycle, noise otherwise.
    initial begin
        logic        rd;
        logic [31:0] a;
        m_rdata_i = 32'd0;
        forever begin
            @(negedge clk_i);
            rd = m_rd_o;
            a  = m_addr_o;
            @(posedge clk_i);
            m_rdata_i = rd ? mem_val(a) : $urandom();
        end
    end

    // ---------------- reference model + request-side checker ----------------
    initial begin
        int          run;
        logic [31:0] ist, dst;
        logic        eig, edg;
        run = 0;
        ist = '0;
        dst = '0;
        forever begin
            @(negedge clk_i);
            if (reset_i !== 1'b1) begin
                chk("rst_i_gnt", i_gnt_o, 0);
                chk("rst_d_gnt", d_gnt_o, 0);
                chk("rst_m_rd", m_rd_o, 0);
                chk("rst_m_wr", m_wr_o, 0);
                chk("rst_state", dbg_state_o, 0);
                chk("rst_i_stall", i_stall_cnt_o, 0);
                chk("rst_d_stall", d_stall_cnt_o, 0);
                run = 0;
                ist = '0;
                dst = '0;
            end else begin
                // Data wins contention until instruction has been refused STARVE times in a row.
                eig = i_req_i && (!d_req_i || run >= ((STARVE < 1) ? 1 : STARVE));
                edg = d_req_i && !eig;
                chk("i_gnt", i_gnt_o, eig);
                chk("d_gnt", d_gnt_o, edg);
`ifdef RISCV_MEM_ARBITER_STATS_EN
                chk("i_stall_cnt", i_stall_cnt_o, ist);
                chk("d_stall_cnt", d_stall_cnt_o, dst);
`else
                chk("i_stall_cnt", i_stall_cnt_o, 0);
                chk("d_stall_cnt", d_stall_cnt_o, 0);
`endif
                if (eig) begin
                    chk("m_addr_i", m_addr_o, i_addr_i);
                    chk("m_rd_i", m_rd_o, 1);
                    chk("m_wr_i", m_wr_o, 0);
                    chk("m_size_i", m_size_o, 2);
                    i_exp_q.push_back(mem_val(i_addr_i));
                    i_due_q.push_back(cyc + 1);
                end else if (edg) begin
                    chk("m_addr_d", m_addr_o, d_addr_i);
                    chk("m_rd_d", m_rd_o, !d_we_i);
                    chk("m_wr_d", m_wr_o, d_we_i);
                    chk("m_size_d", m_size_o, d_size_i);
                    if (d_we_i) chk("m_wdata", m_wdata_o, d_wdata_i);
                    else begin
                        d_exp_q.push_back(mem_val(d_addr_i));
                        d_due_q.push_back(cyc + 1);
                    end
                end else begin
                    chk("m_rd_idle", m_rd_o, 0);
                    chk("m_wr_idle", m_wr_o, 0);
                    chk("m_addr_idle", m_addr_o, 0);
                end
                if (i_req_i && !eig) run++;
                else run = 0;
                if (i_req_i && !eig && ist != 32'hFFFF_FFFF) ist++;
                if (d_req_i && !edg && dst != 32'hFFFF_FFFF) dst++;
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        logic ev;
        forever begin
            @(negedge clk_i);
            if (reset_i !== 1'b1) begin
                i_exp_q.delete();
                i_due_q.delete();
                d_exp_q.delete();
                d_due_q.delete();
                chk("rst_i_rvalid", i_rvalid_o, 0);
                chk("rst_d_rvalid", d_rvalid_o, 0);
                chk("rst_i_rdata", i_rdata_o, 0);
                chk("rst_d_rdata", d_rdata_o, 0);
            end else begin
                ev = (i_due_q.size() > 0) && (i_due_q[0] == cyc);
                chk("i_rvalid", i_rvalid_o, ev);
                if (ev) begin
                    chk("i_rdata", i_rdata_o, i_exp_q.pop_front());
                    void'(i_due_q.pop_front());
                end else chk("i_rdata_idle", i_rdata_o, 0);
                ev = (d_due_q.size() > 0) && (d_due_q[0] == cyc);
                chk("d_rvalid", d_rvalid_o, ev);
                if (ev) begin
                    chk("d_rdata", d_rdata_o, d_exp_q.pop_front());
                    void'(d_due_q.pop_front());
                end else chk("d_rdata_idle", d_rdata_o, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_random(input int n);
        logic ig, dg;
        ig = 1'b0;
        dg = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (i_req_i && ig) i_req_i = 1'b0;
            if (d_req_i && dg) d_req_i = 1'b0;
            if (!i_req_i && $urandom_range(0, 99) < 60) begin
                i_req_i  = 1'b1;
                i_addr_i = {$urandom_range(0, 65535), 2'b00};
            end
            if (!d_req_i && $urandom_range(0, 99) < 70) begin
                d_req_i   = 1'b1;
                d_we_i    = ($urandom_range(0, 2) == 0);
                d_addr_i  = $urandom();
                d_wdata_i = $urandom();
                d_size_i  = 2'($urandom_range(0, 2));
            end
            @(negedge clk_i);
            ig = i_gnt_o;
            dg = d_gnt_o;
        end
        tick();
        i_req_i = 1'b0;
        d_req_i = 1'b0;
    endtask

    initial begin
        logic saw_i;
        reset_i   = 1'b0;
        i_req_i   = 1'b0;
        i_addr_i  = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = '0;
        d_wdata_i = '0;
        d_size_i  = '0;
        tick();
        tick();
        @(negedge clk_i);
        chk("reset_state", dbg_state_o, 0);
        tick();
        reset_i = 1'b1;

        // Single instruction fetch.
        tick();
        i_req_i  = 1'b1;
        i_addr_i = 32'h100;
        @(negedge clk_i);
        chk("fetch_gnt", i_gnt_o, 1);
        chk("fetch_m_addr", m_addr_o, 32'h100);
        chk("fetch_m_rd", m_rd_o, 1);
        tick();
        i_req_i = 1'b0;
        @(negedge clk_i);
        chk("fetch_rvalid", i_rvalid_o, 1);
        chk("fetch_rdata", i_rdata_o, 32'h13);

        // Data word write: no read response.
        tick();
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h40;
        d_wdata_i = 32'hDEAD_BEEF;
        d_size_i  = 2'd2;
        @(negedge clk_i);
        chk("wr_gnt", d_gnt_o, 1);
        chk("wr_m_wr", m_wr_o, 1);
        chk("wr_m_wdata", m_wdata_o, 32'hDEAD_BEEF);
        tick();
        d_req_i = 1'b0;
        @(negedge clk_i);
        chk("wr_no_rvalid", d_rvalid_o, 0);

        // Contention: data wins STARVE times, then instruction, then data again.
        tick();
        i_req_i  = 1'b1;
        i_addr_i = 32'h200;
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h2000;
        d_size_i = 2'd2;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            saw_i = i_gnt_o;
            chk($sformatf("starve_i_gnt%0d", k), i_gnt_o, (k == STARVE));
            chk($sformatf("starve_d_gnt%0d", k), d_gnt_o, (k != STARVE));
            tick();
            if (saw_i) i_req_i = 1'b0;
        end
        d_req_i = 1'b0;

        // Stall statistics after a fresh reset: three refused instruction cycles.
        do_reset();
        i_req_i  = 1'b1;
        i_addr_i = 32'h300;
        d_req_i  = 1'b1;
        d_addr_i = 32'h2004;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            tick();
        end
        d_req_i = 1'b0;
        @(negedge clk_i);
`ifdef RISCV_MEM_ARBITER_STATS_EN
        chk("stats_i_stall3", i_stall_cnt_o, 3);
`else
        chk("stats_i_stall3", i_stall_cnt_o, 0);
`endif
        tick();
        i_req_i = 1'b0;

        // Reset in the response cycle of a read: the response is dropped.
        tick();
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h3000;
        @(negedge clk_i);
        tick();
        d_req_i = 1'b0;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_drop_rvalid", d_rvalid_o, 0);
        chk("rst_drop_state", dbg_state_o, 0);
        tick();
        reset_i = 1'b1;
        tick();
        @(negedge clk_i);
        chk("post_rst_rvalid", d_rvalid_o, 0);

        // Alternating single-requester reads, one grant per cycle.
        for (int k = 0; k < 12; k++) begin
            tick();
            i_req_i  = (k % 2 == 0);
            d_req_i  = (k % 2 == 1);
            d_we_i   = 1'b0;
            i_addr_i = {$urandom_range(0, 4095), 2'b00};
            d_addr_i = $urandom();
            @(negedge clk_i);
            chk("alt_one_grant", i_gnt_o + d_gnt_o, 1);
        end
        tick();
        i_req_i = 1'b0;
        d_req_i = 1'b0;

        run_random(400);

        tick();
        tick();
        tick();
        @(negedge clk_i);
        chk("i_pending_left", i_exp_q.size(), 0);
        chk("d_pending_left", d_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
